// File: rtl/interp_seq_pkg.sv
// Shared types and constants for the interpolator LUT sequencer.
package interp_seq_pkg;

    localparam int NUM_WEIGHTS = 8;
    localparam int WADDR_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } seq_state_t;

    // Config writes and new commits are locked out while a bank swap is pending.
    function automatic logic is_busy(input seq_state_t state);
        return (state == DRAIN) || (state == SWAP);
    endfunction

endpackage

// File: rtl/interp_seq_out_fifo.sv
// Show-ahead synchronous result FIFO with occupancy count; head reads 0 when empty.
module interp_seq_out_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/interp_lut_sequencer.sv
// Sequencer for the 8-segment interpolator: double-buffered weights, credit-based issue, result FIFO.
// Optional performance counters are enabled with INTERP_SEQ_PERF_CNT_EN.
module interp_lut_sequencer
    import interp_seq_pkg::*;
#(
    parameter int BW_X       = 8,
    parameter int BW_WEIGHT  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [WADDR_W-1:0]               cfg_addr,
    input  logic [BW_WEIGHT-1:0]             cfg_wdata,
    input  logic                             cfg_commit,
    output logic                             cfg_busy,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [BW_X-1:0]                  s_x,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [BW_WEIGHT-1:0]             m_y,
    output logic                             o_interp_en,
    output logic [BW_X-1:0]                  o_interp_x,
    output logic [NUM_WEIGHTS*BW_WEIGHT-1:0] o_interp_weights,
    input  logic [BW_WEIGHT-1:0]             i_interp_y
`ifdef INTERP_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_samples,
    output logic [31:0]                      perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [BW_WEIGHT-1:0] r_shadow [NUM_WEIGHTS];
    logic [BW_WEIGHT-1:0] r_active [NUM_WEIGHTS];
    logic                 r_inflight;
    logic                 w_issue;
    logic                 w_pop;
    logic                 w_fifo_empty;
    logic [CW-1:0]        w_fifo_count;
    logic [CW:0]          w_occupancy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cfg_commit) w_state_next = SWAP;
            RUN:     if (cfg_commit) w_state_next = DRAIN;
            DRAIN:   if (!r_inflight) w_state_next = SWAP;
            SWAP:    w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    assign cfg_busy = is_busy(r_state);

    // Credit counts the sample still in the datapath so the FIFO can never overflow.
    assign w_occupancy = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
    assign s_ready     = (r_state == RUN) && (w_occupancy < DEPTH_L);
    assign w_issue     = s_valid && s_ready;
    assign o_interp_en = w_issue;
    assign o_interp_x  = w_issue ? s_x : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_weight
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow[gi] <= '0;
                end else if (cfg_we && !cfg_busy && (cfg_addr == WADDR_W'(gi))) begin
                    r_shadow[gi] <= cfg_wdata;
                end
            end

            // The active bank only moves in SWAP, which is reached with the datapath empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_active[gi] <= '0;
                end else if (r_state == SWAP) begin
                    r_active[gi] <= r_shadow[gi];
                end
            end

            assign o_interp_weights[gi*BW_WEIGHT +: BW_WEIGHT] = r_active[gi];
        end
    endgenerate

    assign m_valid = !w_fifo_empty;
    assign w_pop   = m_valid && m_ready;

    interp_seq_out_fifo #(
        .WIDTH (BW_WEIGHT),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (i_interp_y),
        .i_pop   (w_pop),
        .o_data  (m_y),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

`ifdef INTERP_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_samples;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_samples <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_issue && (r_perf_samples != '1)) begin
                r_perf_samples <= r_perf_samples + 32'd1;
            end
            if (s_valid && !s_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_samples = r_perf_samples;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
